mig_ui_arbiter: RTL
===================

Name: mig_ui_arbiter

Overview:
- Two-requester arbiter and sequencer for the Virtex-7 MIG user interface (app_*) on VC707/KC705 designs.
- Accepts single-beat 512-bit read/write requests from two on-chip masters (e.g. AHB bridge, scrubber/DMA).
- Grants requesters round-robin, drives app_en/app_wdf_* with full app_rdy/app_wdf_rdy handshaking.
- Routes returning read data back to the originating requester through an in-order tag FIFO.

Parameters:
- RDQ_DEPTH, 4: maximum outstanding reads; also the tag FIFO depth (power of two, 2..16).
- ADDR_W, 28: app_addr width.

Ports:
- ui_clk  in  1  MIG user clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- init_calib_complete  in  1  MIG calibration done.
- r0_req / r1_req  in  1  request valid; held until ack.
- r0_we / r1_we  in  1  1 = write, 0 = read.
- r0_addr / r1_addr  in  ADDR_W  MIG address (8-aligned, one 512-bit beat).
- r0_wdata / r1_wdata  in  512  write data.
- r0_wmask / r1_wmask  in  64  byte mask; 1 = byte not written.
- r0_ack / r1_ack  out  1  one-cycle grant pulse.
- r0_rdata / r1_rdata  out  512  read data.
- r0_rvalid / r1_rvalid  out  1  one-cycle read data strobe.
- app_addr  out  ADDR_W  MIG address.
- app_cmd  out  3  1 = read, 0 = write.
- app_en  out  1  command valid.
- app_wdf_data  out  512  write data.
- app_wdf_mask  out  64  write mask.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equal to app_wdf_wren (single beat).
- app_rdy  in  1  command accepted when high with app_en.
- app_wdf_rdy  in  1  write data accepted when high with app_wdf_wren.
- app_rd_data  in  512  read data.
- app_rd_data_valid  in  1  read data strobe.
- app_rd_data_end  in  1  ignored (single beat).
- err  out  1  sticky; set on read data arriving with an empty tag FIFO.

Behaviour:
- Reset (rstn = 0 at an edge):
  - All outputs 0, app_cmd = 0, err = 0.
  - State WAIT_CAL, round-robin pointer = r0, tag FIFO empty, outstanding count = 0.
- All outputs are registered.
- States: WAIT_CAL, IDLE, CMD.
- WAIT_CAL -> IDLE at the first edge sampling init_calib_complete = 1.
- IDLE:
  - Eligible requester: req = 1, and for a read, outstanding < RDQ_DEPTH.
  - If both are eligible, grant the one not granted last. If only one is eligible, grant it, even when the other is requesting but read-blocked.
  - On the grant edge:
    - latch addr/we/wdata/wmask into app_*;
    - set app_en = 1, and set app_wdf_wren = app_wdf_end = 1 for a write;
    - pulse rN_ack for exactly one cycle;
    - for a read, push tag N and increment outstanding;
    - update the round-robin pointer; go to CMD.
  - init_calib_complete = 0 in IDLE -> WAIT_CAL, with no grant that edge.
- CMD:
  - app_en held until an edge samples app_rdy = 1, then cleared on that edge.
  - app_wdf_wren/app_wdf_end held independently until app_wdf_rdy = 1 is sampled.
  - Data may be accepted before, with, or after the command.
  - Go to IDLE on the edge where the last outstanding handshake completes.
  - App outputs are stable while held. A calibration drop during CMD is ignored until IDLE.
- Throughput: at most one command per 2 cycles; the requester's ack follows the edge that samples req by 1 cycle.
- Read return:
  - Each app_rd_data_valid beat pops the FIFO head tag.
  - The next cycle, rTAG_rdata <= app_rd_data and rTAG_rvalid = 1 for one cycle; the other requester's rdata holds its value and its rvalid = 0.
  - Return order equals issue order.
- Outstanding counter:
  - +1 on read grant, -1 on return beat; both on the same edge -> unchanged.
  - Never exceeds RDQ_DEPTH, never wraps below 0.
- Empty FIFO with app_rd_data_valid: no rvalid, counter unchanged, err <= 1 (sticky until reset).
- Reset mid-operation aborts any held command. Late read data returning after reset sets err; this is expected behaviour.

Test Plan:
- Calibration gating: r0 read request held with init_calib_complete = 0 for 10 cycles -> no app_en/ack. Raise calibration -> app_en + r0_ack 1 cycle later, app_cmd = 1.
- Write handshake: r1 write addr 0x40, wdata = 512'hA5.., wmask = 64'h0F, app_rdy = 0 for 3 cycles, app_wdf_rdy = 1 -> app_wdf_wren drops after 1 cycle. app_en is held 4 cycles with values stable, then IDLE.
- Round-robin: both requesting reads continuously, last grant r0 -> grant sequence r1, r0, r1, r0, acks alternate.
- Outstanding limit: RDQ_DEPTH = 4, 4 r0 reads issued with no return -> 5th r0 read stalls while an r1 write is granted. One return beat -> r0 is granted next.
- Routing: interleaved reads r0 @0x00, r1 @0x08, r0 @0x10; return beats D0, D1, D2 -> r0_rvalid with D0, r1_rvalid with D1, r0_rvalid with D2, each 1 cycle after its beat.
- Error/reset: app_rd_data_valid with empty FIFO -> err = 1, persists. rstn = 0 during CMD -> all outputs 0 next edge, err cleared, state WAIT_CAL.

Source files
------------

// File: rtl/mig_ui_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the MIG app_* user interface.
// Read data is routed back to its requester through an in-order tag FIFO.
module mig_ui_arbiter #(
   parameter int unsigned RDQ_DEPTH = 4,
   parameter int unsigned ADDR_W    = 28
) (
   input  logic              ui_clk,
   input  logic              rstn,
   input  logic              init_calib_complete,

   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [511:0]      r0_wdata,
   input  logic [63:0]       r0_wmask,
   output logic              r0_ack,
   output logic [511:0]      r0_rdata,
   output logic              r0_rvalid,

   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [511:0]      r1_wdata,
   input  logic [63:0]       r1_wmask,
   output logic              r1_ack,
   output logic [511:0]      r1_rdata,
   output logic              r1_rvalid,

   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   output logic [511:0]      app_wdf_data,
   output logic [63:0]       app_wdf_mask,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_rdy,
   input  logic              app_wdf_rdy,
   input  logic [511:0]      app_rd_data,
   input  logic              app_rd_data_valid,
   input  logic              app_rd_data_end,

   output logic              err
);

   localparam int unsigned PTR_W = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      WAIT_CAL = 2'd0,
      IDLE     = 2'd1,
      CMD      = 2'd2
   } state_t;

   state_t               state;
   logic                 last_r1;
   logic [CNT_W-1:0]     outstanding;
   logic [RDQ_DEPTH-1:0] tag_mem;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;

   logic                 read_room;
   logic                 elig0;
   logic                 elig1;
   logic                 pick1;
   logic                 grant;
   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [511:0]         sel_wdata;
   logic [63:0]          sel_wmask;
   logic                 push;
   logic                 pop;
   logic                 head_tag;
   logic                 cmd_done;

   // Single-beat interface: the data-end strobe carries no extra information.
   logic                 unused_rd_end;
   assign unused_rd_end = app_rd_data_end;

   always_comb begin
      read_room = outstanding < CNT_W'(RDQ_DEPTH);
      elig0     = r0_req && (r0_we || read_room);
      elig1     = r1_req && (r1_we || read_room);
      // r1 wins when it is the only eligible one, or on a tie when r0 went last.
      pick1     = elig1 && (!elig0 || !last_r1);
      grant     = (state == IDLE) && init_calib_complete && (elig0 || elig1);
      sel_we    = pick1 ? r1_we    : r0_we;
      sel_addr  = pick1 ? r1_addr  : r0_addr;
      sel_wdata = pick1 ? r1_wdata : r0_wdata;
      sel_wmask = pick1 ? r1_wmask : r0_wmask;
      push      = grant && !sel_we;
      pop       = app_rd_data_valid && (outstanding != '0);
      head_tag  = tag_mem[rd_ptr];
      cmd_done  = (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);
   end

   always_ff @(posedge ui_clk) begin
      if (!rstn) begin
         state        <= WAIT_CAL;
         last_r1      <= 1'b0;
         outstanding  <= '0;
         tag_mem      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         r0_ack       <= 1'b0;
         r1_ack       <= 1'b0;
         r0_rdata     <= '0;
         r1_rdata     <= '0;
         r0_rvalid    <= 1'b0;
         r1_rvalid    <= 1'b0;
         app_addr     <= '0;
         app_cmd      <= '0;
         app_en       <= 1'b0;
         app_wdf_data <= '0;
         app_wdf_mask <= '0;
         app_wdf_wren <= 1'b0;
         app_wdf_end  <= 1'b0;
         err          <= 1'b0;
      end else begin
         r0_ack    <= 1'b0;
         r1_ack    <= 1'b0;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;

         case (state)
            WAIT_CAL: begin
               if (init_calib_complete) state <= IDLE;
            end
            IDLE: begin
               if (!init_calib_complete) begin
                  state <= WAIT_CAL;
               end else if (grant) begin
                  app_addr     <= sel_addr;
                  app_cmd      <= sel_we ? 3'd0 : 3'd1;
                  app_en       <= 1'b1;
                  app_wdf_data <= sel_wdata;
                  app_wdf_mask <= sel_wmask;
                  app_wdf_wren <= sel_we;
                  app_wdf_end  <= sel_we;
                  r0_ack       <= !pick1;
                  r1_ack       <= pick1;
                  last_r1      <= pick1;
                  state        <= CMD;
               end
            end
            CMD: begin
               // Command and write data complete independently, in either order.
               if (app_rdy) app_en <= 1'b0;
               if (app_wdf_rdy) begin
                  app_wdf_wren <= 1'b0;
                  app_wdf_end  <= 1'b0;
               end
               if (cmd_done) state <= IDLE;
            end
            default: state <= WAIT_CAL;
         endcase

         if (push) begin
            tag_mem[wr_ptr] <= pick1;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end

         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            if (head_tag) begin
               r1_rdata  <= app_rd_data;
               r1_rvalid <= 1'b1;
            end else begin
               r0_rdata  <= app_rd_data;
               r0_rvalid <= 1'b1;
            end
         end else if (app_rd_data_valid) begin
            err <= 1'b1;
         end

         outstanding <= outstanding + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule
